// File: rtl/c432_irq_ack_if.sv
// Handshake bundle between the c432 priority core, the acknowledge responder and the CPU.
interface c432_irq_ack_if;
    logic       pa;
    logic       pb;
    logic       pc;
    logic [3:0] chan;
    logic       cpu_ack;
    logic       cpu_irq;
    logic [5:0] cpu_vec;
    logic [8:0] clr_a;
    logic [8:0] clr_b;
    logic [8:0] clr_c;
    logic       busy;
    logic       err;

    modport master (
        output pa, pb, pc, chan, cpu_ack,
        input  cpu_irq, cpu_vec, clr_a, clr_b, clr_c, busy, err
    );

    modport slave (
        input  pa, pb, pc, chan, cpu_ack,
        output cpu_irq, cpu_vec, clr_a, clr_b, clr_c, busy, err
    );
endinterface

// File: rtl/c432_irq_ack_responder.sv
// CPU-side interrupt acknowledge responder for the 27-channel c432 controller.
// Optional DROP-state timeout is enabled by defining IRQ_ACK_TIMEOUT_EN.
module c432_irq_ack_responder #(
    parameter int unsigned CLR_CYCLES = 2,
    parameter int unsigned TIMEOUT    = 16
) (
    input  logic          clk,
    input  logic          rst_n,
    c432_irq_ack_if.slave bus_if
);
    localparam int unsigned ChW  = 4;
    localparam int unsigned CntW = 4;
    localparam int unsigned ClrW = 9;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        LATCH = 3'd1,
        REQ   = 3'd2,
        CLEAR = 3'd3,
        DROP  = 3'd4
    } state_e;

    state_e          state_q;
    logic            pa_q, pb_q, pc_q;
    logic [ChW-1:0]  chan_q;
    logic [1:0]      bus_q;
    logic [ChW-1:0]  ch_q;
    logic            cpu_irq_q;
    logic [5:0]      cpu_vec_q;
    logic [ClrW-1:0] clr_a_q, clr_b_q, clr_c_q;
    logic [CntW-1:0] clr_cnt_q;
    logic            busy_q;
    logic            err_q;

    logic [1:0]      bus_d;
    logic            req_hold;
    logic [ClrW-1:0] clr_mask;

    // Bus priority A > B > C on the sampled flags; codes 1/2/3.
    always_comb begin
        bus_d = 2'd3;
        if (pa_q)      bus_d = 2'd1;
        else if (pb_q) bus_d = 2'd2;
    end

    // Request still present for the latched bus and channel.
    always_comb begin
        req_hold = 1'b0;
        case (bus_q)
            2'd1:    req_hold = pa_q;
            2'd2:    req_hold = pb_q;
            default: req_hold = pc_q;
        endcase
        req_hold = req_hold && (chan_q == ch_q);
    end

    assign clr_mask = ClrW'(1) << ch_q;

`ifdef IRQ_ACK_TIMEOUT_EN
    logic [7:0] tmo_q;
`else
    logic [7:0] tmo_unused;
    assign tmo_unused = 8'(TIMEOUT);
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            pa_q      <= 1'b0;
            pb_q      <= 1'b0;
            pc_q      <= 1'b0;
            chan_q    <= '0;
            bus_q     <= '0;
            ch_q      <= '0;
            cpu_irq_q <= 1'b0;
            cpu_vec_q <= '0;
            clr_a_q   <= '0;
            clr_b_q   <= '0;
            clr_c_q   <= '0;
            clr_cnt_q <= '0;
            busy_q    <= 1'b0;
            err_q     <= 1'b0;
`ifdef IRQ_ACK_TIMEOUT_EN
            tmo_q     <= '0;
`endif
        end else begin
            pa_q   <= bus_if.pa;
            pb_q   <= bus_if.pb;
            pc_q   <= bus_if.pc;
            chan_q <= bus_if.chan;

            case (state_q)
                IDLE: begin
                    if (pa_q || pb_q || pc_q) begin
                        bus_q   <= bus_d;
                        ch_q    <= chan_q;
                        busy_q  <= 1'b1;
                        state_q <= LATCH;
                    end
                end
                LATCH: begin
                    if (ch_q > 4'd8) begin
                        err_q   <= 1'b1;
                        busy_q  <= 1'b0;
                        state_q <= IDLE;
                    end else begin
                        cpu_irq_q <= 1'b1;
                        cpu_vec_q <= {bus_q, ch_q};
                        state_q   <= REQ;
                    end
                end
                REQ: begin
                    if (bus_if.cpu_ack) begin
                        cpu_irq_q <= 1'b0;
                        cpu_vec_q <= '0;
                        clr_cnt_q <= CntW'(CLR_CYCLES - 1);
                        case (bus_q)
                            2'd1:    clr_a_q <= clr_mask;
                            2'd2:    clr_b_q <= clr_mask;
                            default: clr_c_q <= clr_mask;
                        endcase
                        state_q <= CLEAR;
                    end
                end
                CLEAR: begin
                    if (clr_cnt_q == '0) begin
                        clr_a_q <= '0;
                        clr_b_q <= '0;
                        clr_c_q <= '0;
`ifdef IRQ_ACK_TIMEOUT_EN
                        tmo_q   <= '0;
`endif
                        state_q <= DROP;
                    end else begin
                        clr_cnt_q <= clr_cnt_q - CntW'(1);
                    end
                end
                DROP: begin
                    if (!req_hold) begin
                        busy_q  <= 1'b0;
                        state_q <= IDLE;
                    end
`ifdef IRQ_ACK_TIMEOUT_EN
                    else if (tmo_q == 8'(TIMEOUT - 1)) begin
                        err_q   <= 1'b1;
                        busy_q  <= 1'b0;
                        state_q <= IDLE;
                    end else begin
                        tmo_q <= tmo_q + 8'd1;
                    end
`endif
                end
                default: begin
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign bus_if.cpu_irq = cpu_irq_q;
    assign bus_if.cpu_vec = cpu_vec_q;
    assign bus_if.clr_a   = clr_a_q;
    assign bus_if.clr_b   = clr_b_q;
    assign bus_if.clr_c   = clr_c_q;
    assign bus_if.busy    = busy_q;
    assign bus_if.err     = err_q;
endmodule

// File: tb/tb_c432_irq_ack_responder.sv
// Directed self-checking bench for c432_irq_ack_responder (CLR_CYCLES=2, TIMEOUT=16).
module tb_c432_irq_ack_responder;
    logic clk;
    logic rst_n;
    int   checks;
    int   failures;

    c432_irq_ack_if bif ();

    c432_irq_ack_responder #(
        .CLR_CYCLES(2),
        .TIMEOUT   (16)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus_if(bif.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic idle_inputs();
        bif.pa = 1'b0; bif.pb = 1'b0; bif.pc = 1'b0;
        bif.chan = 4'd0; bif.cpu_ack = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        bif.pa = 1'($urandom); bif.pb = 1'($urandom); bif.pc = 1'($urandom);
        bif.chan = 4'($urandom); bif.cpu_ack = 1'($urandom);
        repeat (3) @(negedge clk);
        checks++;
        if ({bif.cpu_irq, bif.cpu_vec, bif.clr_a, bif.clr_b, bif.clr_c, bif.busy, bif.err} !== 36'd0) begin
            failures++;
            $display("FAIL reset_outputs irq=%b vec=%h a=%h b=%h c=%h busy=%b err=%b required all 0",
                     bif.cpu_irq, bif.cpu_vec, bif.clr_a, bif.clr_b, bif.clr_c, bif.busy, bif.err);
        end
        idle_inputs();
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        checks++;
        if (bif.busy !== 1'b0 || bif.cpu_irq !== 1'b0) begin
            failures++;
            $display("FAIL reset_release busy=%b irq=%b required 0 0", bif.busy, bif.cpu_irq);
        end
    endtask

    task automatic test_single_b();
        int n;
        bif.pb = 1'b1; bif.chan = 4'd5;
        n = 0;
        while (bif.cpu_irq !== 1'b1 && n < 8) begin @(negedge clk); n++; end
        checks++;
        if (n !== 3) begin
            failures++;
            $display("FAIL irq_latency got=%0d clocks required=3", n);
        end
        repeat (3) @(negedge clk);
        checks++;
        if (bif.cpu_irq !== 1'b1 || bif.cpu_vec !== 6'h25) begin
            failures++;
            $display("FAIL vec_b irq=%b vec=%h required 1 25", bif.cpu_irq, bif.cpu_vec);
        end
        bif.cpu_ack = 1'b1;
        @(negedge clk);
        checks++;
        if (bif.clr_b !== 9'h020 || bif.cpu_irq !== 1'b0 || bif.clr_a !== 9'h0 || bif.clr_c !== 9'h0) begin
            failures++;
            $display("FAIL clr_b_first b=%h a=%h c=%h irq=%b required 020 0 0 0",
                     bif.clr_b, bif.clr_a, bif.clr_c, bif.cpu_irq);
        end
        bif.cpu_ack = 1'b0;
        @(negedge clk);
        checks++;
        if (bif.clr_b !== 9'h020) begin
            failures++;
            $display("FAIL clr_b_second b=%h required 020", bif.clr_b);
        end
        @(negedge clk);
        checks++;
        if (bif.clr_b !== 9'h000 || bif.busy !== 1'b1) begin
            failures++;
            $display("FAIL clr_b_end b=%h busy=%b required 000 1", bif.clr_b, bif.busy);
        end
        bif.pb = 1'b0;
        repeat (2) @(negedge clk);
        checks++;
        if (bif.busy !== 1'b0 || bif.err !== 1'b0) begin
            failures++;
            $display("FAIL drop_b_idle busy=%b err=%b required 0 0", bif.busy, bif.err);
        end
    endtask

    task automatic test_priority();
        int n;
        bif.pa = 1'b1; bif.pb = 1'b1; bif.pc = 1'b1; bif.chan = 4'd0;
        n = 0;
        while (bif.cpu_irq !== 1'b1 && n < 8) begin @(negedge clk); n++; end
        checks++;
        if (bif.cpu_vec !== 6'h10) begin
            failures++;
            $display("FAIL prio_vec_a vec=%h required 10", bif.cpu_vec);
        end
        bif.cpu_ack = 1'b1;
        @(negedge clk);
        bif.cpu_ack = 1'b0;
        checks++;
        if ({bif.clr_a, bif.clr_b, bif.clr_c} !== {9'h001, 9'h000, 9'h000}) begin
            failures++;
            $display("FAIL prio_clr a=%h b=%h c=%h required 001 000 000", bif.clr_a, bif.clr_b, bif.clr_c);
        end
        repeat (2) @(negedge clk);
        bif.pa = 1'b0; bif.pb = 1'b0;
        n = 0;
        while (bif.cpu_irq !== 1'b1 && n < 12) begin @(negedge clk); n++; end
        checks++;
        if (bif.cpu_irq !== 1'b1 || bif.cpu_vec !== 6'h30) begin
            failures++;
            $display("FAIL pending_c_vec irq=%b vec=%h required 1 30", bif.cpu_irq, bif.cpu_vec);
        end
        bif.cpu_ack = 1'b1;
        @(negedge clk);
        bif.cpu_ack = 1'b0;
        checks++;
        if ({bif.clr_a, bif.clr_b, bif.clr_c} !== {9'h000, 9'h000, 9'h001}) begin
            failures++;
            $display("FAIL pending_c_clr a=%h b=%h c=%h required 000 000 001", bif.clr_a, bif.clr_b, bif.clr_c);
        end
        bif.pc = 1'b0;
        n = 0;
        while (bif.busy !== 1'b0 && n < 10) begin @(negedge clk); n++; end
        checks++;
        if (bif.busy !== 1'b0) begin
            failures++;
            $display("FAIL pending_c_idle busy=%b required 0", bif.busy);
        end
    endtask

    task automatic test_bad_channel();
        logic saw_irq;
        saw_irq = 1'b0;
        bif.pc = 1'b1; bif.chan = 4'hB;
        @(negedge clk);
        bif.pc = 1'b0; bif.chan = 4'd0;
        saw_irq = saw_irq | bif.cpu_irq;
        repeat (2) begin @(negedge clk); saw_irq = saw_irq | bif.cpu_irq; end
        checks++;
        if (bif.err !== 1'b1 || bif.busy !== 1'b0 || saw_irq !== 1'b0) begin
            failures++;
            $display("FAIL bad_chan err=%b busy=%b irq_seen=%b required 1 0 0", bif.err, bif.busy, saw_irq);
        end
        repeat (4) @(negedge clk);
        checks++;
        if (bif.err !== 1'b1) begin
            failures++;
            $display("FAIL err_sticky err=%b required 1", bif.err);
        end
    endtask

    task automatic test_reset_in_clear();
        int n;
        logic [8:0] seen;
        bif.pa = 1'b1; bif.chan = 4'd3;
        n = 0;
        while (bif.cpu_irq !== 1'b1 && n < 8) begin @(negedge clk); n++; end
        bif.cpu_ack = 1'b1;
        @(negedge clk);
        checks++;
        if (bif.clr_a !== 9'h008) begin
            failures++;
            $display("FAIL clear_before_reset a=%h required 008", bif.clr_a);
        end
        rst_n = 1'b0;
        idle_inputs();
        #1;
        checks++;
        if (bif.clr_a !== 9'h0 || bif.busy !== 1'b0 || bif.err !== 1'b0) begin
            failures++;
            $display("FAIL async_abort a=%h busy=%b err=%b required 000 0 0", bif.clr_a, bif.busy, bif.err);
        end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        seen = 9'h0;
        repeat (6) begin @(negedge clk); seen = seen | bif.clr_a | bif.clr_b | bif.clr_c; end
        checks++;
        if (seen !== 9'h0 || bif.busy !== 1'b0) begin
            failures++;
            $display("FAIL no_pulse_after_reset clr_or=%h busy=%b required 000 0", seen, bif.busy);
        end
    endtask

    task automatic test_timeout();
        int n;
        bif.pa = 1'b1; bif.chan = 4'd1;
        n = 0;
        while (bif.cpu_irq !== 1'b1 && n < 8) begin @(negedge clk); n++; end
        bif.cpu_ack = 1'b1;
        @(negedge clk);
        bif.cpu_ack = 1'b0;
        n = 0;
        while (bif.clr_a !== 9'h0 && n < 8) begin @(negedge clk); n++; end
`ifdef IRQ_ACK_TIMEOUT_EN
        repeat (15) @(negedge clk);
        checks++;
        if (bif.busy !== 1'b1 || bif.err !== 1'b0) begin
            failures++;
            $display("FAIL timeout_early busy=%b err=%b required 1 0", bif.busy, bif.err);
        end
        @(negedge clk);
        checks++;
        if (bif.busy !== 1'b0 || bif.err !== 1'b1) begin
            failures++;
            $display("FAIL timeout_fire busy=%b err=%b required 0 1", bif.busy, bif.err);
        end
`else
        repeat (20) @(negedge clk);
        checks++;
        if (bif.busy !== 1'b1 || bif.err !== 1'b0) begin
            failures++;
            $display("FAIL drop_wait busy=%b err=%b required 1 0", bif.busy, bif.err);
        end
`endif
        idle_inputs();
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    initial begin
        checks = 0;
        failures = 0;
        rst_n = 1'b0;
        idle_inputs();
        @(negedge clk);
        test_reset();
        test_single_b();
        test_priority();
        test_bad_channel();
        test_reset_in_clear();
        test_timeout();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
